// File: rtl/paddle_rc_emu.sv
// Purpose: emulates the two RC paddle timing networks of the AY-3-8500, integrating digital up/down controls into paddle positions.
// Latency: position updates 3 clocks after vsync rises; pin rises D+4 clocks after dwn falls, and falls 3 clocks after dwn rises.
// Backpressure: none; the block is free-running and every input is sampled through a 2-FF synchroniser.
module paddle_rc_emu #(
    parameter int POS_W     = 8,
    parameter int CNT_W     = 16,
    parameter int MIN_DELAY = 16,
    parameter int SCALE     = 4,
    parameter int SPEED     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             l_up,
    input  logic             l_down,
    input  logic             r_up,
    input  logic             r_down,
    input  logic             l_dwn,
    input  logic             r_dwn,
    output logic             l_pin,
    output logic             r_pin,
    output logic [POS_W-1:0] l_pos,
    output logic [POS_W-1:0] r_pos
);

    localparam int CALC_W = 64;
    localparam logic [POS_W-1:0] POS_MAX = '1;
    localparam logic [POS_W-1:0] POS_RST = (POS_W)'(1) << (POS_W - 1);
    localparam logic [POS_W:0]   SPD_EXT = (POS_W + 1)'(SPEED);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_DISCH  = 2'd1,
        S_CHARGE = 2'd2,
        S_DONE   = 2'd3
    } chg_state_t;

    // Bit map: 0 vsync, 1 l_up, 2 l_down, 3 r_up, 4 r_down, 5 l_dwn, 6 r_dwn
    logic [6:0] raw_in;
    logic [6:0] sync1;
    logic [6:0] sync2;
    logic       vs_prev;
    logic [1:0] dwn_prev;
    logic       frame_tick;

    assign raw_in     = {r_dwn, l_dwn, r_down, r_up, l_down, l_up, vsync};
    assign frame_tick = sync2[0] & ~vs_prev;

    // Two-stage synchronisers plus the previous-value copies used for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            vs_prev  <= 1'b0;
            dwn_prev <= '0;
        end else begin
            sync1    <= raw_in;
            sync2    <= sync1;
            vs_prev  <= sync2[0];
            dwn_prev <= sync2[6:5];
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic              up_s;
        logic              dn_s;
        logic              dwn_s;
        logic              dwn_fall;
        logic [POS_W-1:0]  pos_q;
        logic [POS_W:0]    pos_inc;
        logic [POS_W:0]    pos_dec;
        logic [CALC_W-1:0] load_full;
        logic [CNT_W-1:0]  load_val;
        chg_state_t        state_q;
        chg_state_t        state_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic              pin_q;
        logic              pin_d;

        assign up_s     = sync2[1 + 2 * ch];
        assign dn_s     = sync2[2 + 2 * ch];
        assign dwn_s    = sync2[5 + ch];
        assign dwn_fall = ~dwn_s & dwn_prev[ch];

        // Guard bit catches overflow past POS_MAX and underflow below zero
        assign pos_inc = {1'b0, pos_q} + SPD_EXT;
        assign pos_dec = {1'b0, pos_q} - SPD_EXT;

        // Wide enough that MIN_DELAY + pos*SCALE cannot wrap before saturation
        assign load_full = CALC_W'(MIN_DELAY) + CALC_W'(pos_q) * CALC_W'(SCALE);
        assign load_val  = (load_full > CALC_W'(CNT_MAX)) ? CNT_MAX : load_full[CNT_W-1:0];

        // Per-frame position integrator; opposing or absent requests hold position
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pos_q <= POS_RST;
            end else if (frame_tick && (up_s ^ dn_s)) begin
                if (up_s) begin
                    pos_q <= pos_inc[POS_W] ? POS_MAX : pos_inc[POS_W-1:0];
                end else begin
                    pos_q <= pos_dec[POS_W] ? '0 : pos_dec[POS_W-1:0];
                end
            end
        end

        // Charge FSM state, delay counter and registered pin
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= S_WAIT;
                cnt_q   <= '0;
                pin_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pin_q   <= pin_d;
            end
        end

        // Next-state: WAIT blocks timing until a full discharge has been seen
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pin_d   = pin_q;
            case (state_q)
                S_WAIT: begin
                    if (dwn_s) state_d = S_DISCH;
                end
                S_DISCH: begin
                    if (dwn_fall) begin
                        cnt_d   = load_val;
                        state_d = S_CHARGE;
                    end
                end
                S_CHARGE: begin
                    if (dwn_s) begin
                        state_d = S_DISCH;
                    end else if (cnt_q == '0) begin
                        pin_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - (CNT_W)'(1);
                    end
                end
                S_DONE: begin
                    if (dwn_s) begin
                        pin_d   = 1'b0;
                        state_d = S_DISCH;
                    end
                end
                default: begin
                    state_d = S_WAIT;
                    pin_d   = 1'b0;
                end
            endcase
        end
    end

    assign l_pin = g_ch[0].pin_q;
    assign r_pin = g_ch[1].pin_q;
    assign l_pos = g_ch[0].pos_q;
    assign r_pos = g_ch[1].pos_q;

endmodule

// File: tb/tb_paddle_rc_emu.sv
// Purpose: directed self-checking bench for paddle_rc_emu (default, saturating and narrow-position instances).
// Latency: measures pin rise in clock edges counted from the first edge sampling dwn low.
// Backpressure: not applicable; every wait is bounded by a cycle limit.
module tb_paddle_rc_emu;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       l_up, l_down, r_up, r_down;
    logic       l_dwn, r_dwn;
    logic       l_pin, r_pin;
    logic [7:0] l_pos, r_pos;

    logic       s_dwn;
    logic       s_l_pin, s_r_pin;
    logic [7:0] s_l_pos, s_r_pos;

    logic       c_up, c_down, c_dwn;
    logic       c_l_pin, c_r_pin;
    logic [6:0] c_l_pos, c_r_pos;

    int n_cmp = 0;
    int n_bad = 0;
    int meas;

    always #5 clk = ~clk;

    paddle_rc_emu u_dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .l_up(l_up), .l_down(l_down), .r_up(r_up), .r_down(r_down),
        .l_dwn(l_dwn), .r_dwn(r_dwn),
        .l_pin(l_pin), .r_pin(r_pin), .l_pos(l_pos), .r_pos(r_pos)
    );

    paddle_rc_emu #(.SCALE(300)) u_sat (
        .clk(clk), .reset(reset), .vsync(vsync),
        .l_up(l_up), .l_down(1'b0), .r_up(1'b0), .r_down(1'b0),
        .l_dwn(s_dwn), .r_dwn(1'b0),
        .l_pin(s_l_pin), .r_pin(s_r_pin), .l_pos(s_l_pos), .r_pos(s_r_pos)
    );

    paddle_rc_emu #(.POS_W(7)) u_col (
        .clk(clk), .reset(reset), .vsync(vsync),
        .l_up(c_up), .l_down(c_down), .r_up(1'b0), .r_down(1'b0),
        .l_dwn(c_dwn), .r_dwn(1'b0),
        .l_pin(c_l_pin), .r_pin(c_r_pin), .l_pos(c_l_pos), .r_pos(c_r_pos)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pin_sel(input int which);
        case (which)
            0:       return l_pin;
            1:       return r_pin;
            2:       return s_l_pin;
            default: return c_l_pin;
        endcase
    endfunction

    // Edges until the selected pin is seen high (-1 if the limit expires)
    task automatic measure(input int which, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (pin_sel(which)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_high(input int which, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (pin_sel(which)) n++;
        end
    endtask

    task automatic frame();
        @(negedge clk) vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b0;
        l_up = 0; l_down = 0; r_up = 0; r_down = 0; l_dwn = 0; r_dwn = 0;
        s_dwn = 0; c_up = 0; c_down = 0; c_dwn = 0;

        // Reset state
        #2;
        check("rst_l_pin", 32'(l_pin), 0);
        check("rst_r_pin", 32'(r_pin), 0);
        check("rst_l_pos", 32'(l_pos), 128);
        check("rst_r_pos", 32'(r_pos), 128);
        check("rst_col_pos", 32'(c_l_pos), 64);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("wait_l_pin", 32'(l_pin), 0);

        // First charge at pos 128: 16 + 512 + 4
        l_dwn = 1'b1;
        repeat (10) @(negedge clk);
        check("disch_l_pin", 32'(l_pin), 0);
        l_dwn = 1'b0;
        measure(0, 1000, meas);
        check("first_charge", 32'(meas), 532);
        check("first_l_pos", 32'(l_pos), 128);
        check("first_r_pin", 32'(r_pin), 0);

        // Discharge response: pin falls on edge 3
        @(negedge clk) l_dwn = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("dis_edge2_pin", 32'(l_pin), 1);
        @(posedge clk);
        #1 check("dis_edge3_pin", 32'(l_pin), 0);

        // Upper clamp over 50 frames
        @(negedge clk) l_up = 1'b1;
        repeat (3) @(negedge clk);
        frame();
        check("up_first", 32'(l_pos), 131);
        repeat (41) frame();
        check("up_254", 32'(l_pos), 254);
        frame();
        check("up_255", 32'(l_pos), 255);
        repeat (7) frame();
        check("up_hold", 32'(l_pos), 255);
        check("up_r_pos", 32'(r_pos), 128);
        l_up = 1'b0;

        // Saturated delay: 16 + 255*300 clamps to 65535
        check("sat_pos", 32'(s_l_pos), 255);
        s_dwn = 1'b1;
        repeat (10) @(negedge clk);
        s_dwn = 1'b0;
        measure(2, 70000, meas);
        check("sat_charge", 32'(meas), 65539);

        // Lower clamp, then both held
        @(negedge clk) r_down = 1'b1;
        repeat (3) @(negedge clk);
        repeat (42) frame();
        check("dn_2", 32'(r_pos), 2);
        repeat (8) frame();
        check("dn_0", 32'(r_pos), 0);
        r_up = 1'b1;
        repeat (3) @(negedge clk);
        repeat (3) frame();
        check("both_hold", 32'(r_pos), 0);
        r_up = 1'b0; r_down = 1'b0;
        r_dwn = 1'b1;
        repeat (10) @(negedge clk);
        r_dwn = 1'b0;
        measure(1, 200, meas);
        check("r_charge_pos0", 32'(meas), 20);

        // Abort at pos 255 (D = 1036), then full restart
        @(negedge clk) l_dwn = 1'b0;
        count_high(0, 100, meas);
        check("abort_pre", 32'(meas), 0);
        @(negedge clk) l_dwn = 1'b1;
        count_high(0, 1200, meas);
        check("abort_no_pulse", 32'(meas), 0);
        @(negedge clk) l_dwn = 1'b0;
        measure(0, 2000, meas);
        check("abort_restart", 32'(meas), 1040);

        // Frame tick coincident with load: 64 + 12*3 = 100, delay uses 100
        @(negedge clk) c_up = 1'b1;
        repeat (3) @(negedge clk);
        repeat (12) frame();
        c_up = 1'b0;
        repeat (3) @(negedge clk);
        check("col_pos100", 32'(c_l_pos), 100);
        c_dwn = 1'b1;
        repeat (10) @(negedge clk);
        c_up = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        c_dwn = 1'b0;
        measure(3, 1000, meas);
        check("col_charge", 32'(meas), 420);
        @(negedge clk) vsync = 1'b0;
        c_up = 1'b0;
        check("col_pos103", 32'(c_l_pos), 103);

        // Reset in the middle of a charge
        l_dwn = 1'b1;
        repeat (10) @(negedge clk);
        l_dwn = 1'b0;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_pin", 32'(l_pin), 0);
        check("midrst_pos", 32'(l_pos), 128);
        @(negedge clk) reset = 1'b0;
        count_high(0, 1200, meas);
        check("midrst_wait", 32'(meas), 0);
        @(negedge clk) l_dwn = 1'b1;
        repeat (10) @(negedge clk);
        l_dwn = 1'b0;
        measure(0, 1000, meas);
        check("midrst_recover", 32'(meas), 532);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
